// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter.
// Sends one command byte (start, d0..d7 LSB first, odd parity, stop) and then
// checks for the device's ack. The open-drain lines are driven only through
// active-high "pull low" enables; the top level builds the tri-state pins.
//
// Handshake: in IDLE, tx_req=1 on a clock edge is an accepted request and
// tx_data is latched on that edge. busy is high from the next cycle until the
// cycle in which exactly one of done/err pulses; busy is low in that pulse
// cycle. A request sampled during the pulse cycle is ignored. Requests seen
// while busy are dropped, not queued.
module ps2_host_tx #(
  parameter int CLK_HZ     = 48000000,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH_CYC = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int TO_CYC  = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int TO_W    = $clog2(TO_CYC + 1);
  localparam int INH_W   = $clog2(INH_CYC + 1);
  localparam int MAX_W   = (TO_W > INH_W) ? TO_W : INH_W;
  localparam int CNT_W   = (MAX_W > 24) ? MAX_W : 24;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_BITS      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // state_q is the observable FSM state for checkers bound to this block.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bitcnt_q;
  logic [8:0]       shift_q;
  logic             dat_hold_q;
  logic             done_q, err_q;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic fe, timeout, line_idle, accept;

  // Two-flop synchronisers plus the previous clock sample for edge detection.
  // They reset high so a released bus does not produce a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_in;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fe        = clk_prev_q & ~clk_s2_q;
  assign timeout   = (cnt_q == TO_LAST);
  assign line_idle = clk_s2_q & dat_s2_q;
  assign accept    = tx_req & ~done_q & ~err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a device edge always takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (accept) state_d = ST_INHIBIT;
      ST_INHIBIT:   if (cnt_q == INH_LAST) state_d = ST_START;
      ST_START:     state_d = ST_BITS;
      ST_BITS: begin
        if (fe) begin
          if (bitcnt_q == 4'd9) state_d = ST_ACK;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (fe)           state_d = dat_s2_q ? ST_IDLE : ST_WAIT_IDLE;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (line_idle || timeout) state_d = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // Datapath: cycle/timeout counter, frame shifter, held data level, pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      dat_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          dat_hold_q <= 1'b0;
          if (accept) begin
            shift_q <= {~^tx_data, tx_data};
            cnt_q   <= '0;
          end
        end
        ST_INHIBIT: cnt_q <= cnt_q + CNT_ONE;
        ST_START: begin
          cnt_q      <= '0;
          bitcnt_q   <= '0;
          dat_hold_q <= 1'b1;
        end
        ST_BITS: begin
          if (fe) begin
            cnt_q    <= '0;
            bitcnt_q <= bitcnt_q + 4'd1;
            if (bitcnt_q != 4'd9) begin
              dat_hold_q <= ~shift_q[0];
              shift_q    <= {1'b0, shift_q[8:1]};
            end else begin
              dat_hold_q <= 1'b0;
            end
          end else if (timeout) begin
            err_q      <= 1'b1;
            dat_hold_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_ACK: begin
          if (fe) begin
            cnt_q <= '0;
            if (dat_s2_q) err_q <= 1'b1;
          end else if (timeout) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_WAIT_IDLE: begin
          if (line_idle)    done_q <= 1'b1;
          else if (timeout) err_q  <= 1'b1;
          else              cnt_q  <= cnt_q + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // Line enables and status decoded from the current state.
  always_comb begin
    ps2_clk_oe = (state_q == ST_INHIBIT) || (state_q == ST_START);
    ps2_dat_oe = (state_q == ST_START) || ((state_q == ST_BITS) && dat_hold_q);
    busy       = (state_q != ST_IDLE);
  end

  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a PS/2 device model
// that clocks at 50-cycle half-periods, samples data on its rising clock and
// optionally acks the frame.
module tb_ps2_host_tx;

  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       busy, done, err;

  // Open-drain bus: either side can pull a line low.
  logic dev_clk_low, dev_dat_low;
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.CLK_HZ(1000000), .INHIBIT_US(10), .TIMEOUT_MS(1)) dut (
    .clk(clk), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .tx_req(tx_req),
    .tx_data(tx_data), .busy(busy), .done(done), .err(err)
  );

  // ---------------- clock / reset / cycle stamp ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters and scoreboard ----------------
  int checks = 0, failures = 0;
  int done_cnt = 0, err_cnt = 0, err_cyc = 0, overlap = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_data_q[$];
  logic        rx_perr_q[$];
  logic [11:0] rx_trace_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) begin err_cnt++; err_cyc = cyc; end
    if ((done || err) && busy) overlap++;
  end

  // Reference: what the host should be pulling at each device rising clock.
  // Index 0 is before the first falling edge, index i after falling edge i.
  function automatic logic [11:0] exp_trace(input logic [7:0] b);
    logic [10:0] frame;
    frame = {1'b1, ($countones(b) % 2 == 0), b, 1'b0};
    return {1'b0, ~frame};
  endfunction

  // ---------------- device model ----------------
  bit   dev_arm = 0, dev_active = 0, dev_ack_en = 1;
  int   dev_stop_after = 11, dev_falls = 0;
  int   fall_cyc[1:11];

  initial begin
    logic [10:0] bits;
    logic [11:0] trace;
    int          lim;
    bit          ack;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    forever begin
      @(negedge clk);
      if (dev_arm && ps2_clk_in && !ps2_dat_in) begin
        dev_arm = 0; dev_active = 1; dev_falls = 0;
        lim = dev_stop_after; ack = dev_ack_en;
        bits = '0; trace = '0;
        repeat (HALF) @(negedge clk);
        trace[0] = ps2_dat_oe;
        for (int i = 1; i <= lim; i++) begin
          dev_clk_low = 1'b1; fall_cyc[i] = cyc; dev_falls = i;
          repeat (HALF) @(negedge clk);
          trace[i] = ps2_dat_oe;
          if (i <= 10) bits[i] = ps2_dat_in;
          dev_clk_low = 1'b0;
          if (i == 10 && ack) dev_dat_low = 1'b1;
          repeat (HALF) @(negedge clk);
        end
        dev_dat_low = 1'b0;
        if (lim == 11) begin
          rx_data_q.push_back(bits[8:1]);
          rx_perr_q.push_back(~(^bits[9:1]));
          rx_trace_q.push_back(trace);
        end
        dev_active = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    tx_req = 1'b1; tx_data = b;
    @(negedge clk);
    tx_req = 1'b0; tx_data = 8'($urandom_range(0, 255));
    check("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_cycles", 32'(n), 32'd10);
    check("start_both_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b11);
  endtask

  task automatic wait_end(input int d0, input int e0);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 5000) begin
      @(negedge clk); n++;
    end
    check("end_wait_bound", 32'(n < 5000), 32'd1);
  endtask

  task automatic wait_dev_idle();
    int n = 0;
    while (dev_active && n < 3000) begin
      @(negedge clk); n++;
    end
    check("dev_idle_bound", 32'(n < 3000), 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, input bit inj);
    int d0, e0;
    logic [7:0] eb;
    dev_ack_en = ack; dev_stop_after = 11;
    exp_q.push_back(b);
    d0 = done_cnt; e0 = err_cnt;
    dev_arm = 1;
    send_byte(b);
    if (inj) begin
      repeat (3) begin
        repeat ($urandom_range(50, 300)) @(negedge clk);
        tx_req = 1'b1; tx_data = 8'h55;
        @(negedge clk);
        tx_req = 1'b0;
      end
    end
    wait_end(d0, e0);
    wait_dev_idle();
    check("done_pulses", 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    check("err_pulses", 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
    check("lines_released", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'd0);
    check("rx_frames", 32'(rx_data_q.size()), 32'd1);
    eb = exp_q.pop_front();
    if (rx_data_q.size() > 0) begin
      check("rx_byte", 32'(rx_data_q.pop_front()), 32'(eb));
      check("rx_parity_err", 32'(rx_perr_q.pop_front()), 32'd0);
      check("dat_oe_trace", 32'(rx_trace_q.pop_front()), 32'(exp_trace(eb)));
    end
    if (!ack) check("noack_err_latency", 32'(err_cyc - fall_cyc[11]), 32'd3);
    if (inj) begin
      repeat (30) @(negedge clk);
      check("no_queued_req", 32'({busy, dev_active}), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, e0, n;
    reset = 1'b1; tx_req = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'({ps2_clk_oe, ps2_dat_oe, busy, done, err}), 32'd0);

    // Directed frames: LED command, even-parity case, missing ack.
    run_frame(8'hED, 1'b1, 1'b0);
    run_frame(8'h01, 1'b1, 1'b0);
    run_frame(8'h5A, 1'b0, 1'b0);

    // Device stops clocking after the fourth falling edge.
    dev_ack_en = 1; dev_stop_after = 4;
    d0 = done_cnt; e0 = err_cnt;
    dev_arm = 1;
    send_byte(8'h3C);
    wait_end(d0, e0);
    wait_dev_idle();
    check("to_err", 32'(err_cnt - e0), 32'd1);
    check("to_done", 32'(done_cnt - d0), 32'd0);
    check("to_latency", 32'(err_cyc - fall_cyc[4]), 32'd1003);
    check("to_released", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'd0);
    check("to_no_frame", 32'(rx_data_q.size()), 32'd0);

    // Reset in the middle of the data bits.
    dev_ack_en = 1; dev_stop_after = 11;
    d0 = done_cnt; e0 = err_cnt;
    dev_arm = 1;
    send_byte(8'hA7);
    n = 0;
    while (dev_falls < 5 && n < 3000) begin @(negedge clk); n++; end
    check("fe5_wait_bound", 32'(n < 3000), 32'd1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs", 32'({ps2_clk_oe, ps2_dat_oe, busy, done, err}), 32'd0);
    reset = 1'b0;
    wait_dev_idle();
    check("midreset_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    rx_data_q.delete(); rx_perr_q.delete(); rx_trace_q.delete();
    run_frame(8'hFF, 1'b1, 1'b0);

    // Requests while busy are dropped.
    run_frame(8'hF4, 1'b1, 1'b1);

    // Random bytes.
    for (int k = 0; k < 6; k++) run_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);

    check("busy_with_pulse", 32'(overlap), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
